// File: rtl/mdma_ram_fifo_pkg.sv
// Shared configuration helpers for the RAM-backed FIFO controller and its staging buffer.
package mdma_ram_fifo_pkg;

  localparam int MDMA_RAM_MIN_DEPTH  = 4;
  localparam int MDMA_RAM_MAX_RD_LAT = 2;

  // Legal configurations: power-of-two depth of at least 4 and a read latency of 1 or 2.
  function automatic bit mdma_ram_fifo_cfg_ok(input int depth, input int rd_lat);
    return (depth >= MDMA_RAM_MIN_DEPTH) && ((depth & (depth - 1)) == 0) &&
           (rd_lat >= 1) && (rd_lat <= MDMA_RAM_MAX_RD_LAT);
  endfunction

endpackage

// File: rtl/mdma_ram_fifo_stage.sv
// Small register FIFO that catches RAM read returns and presents the head entry to the consumer.
module mdma_ram_fifo_stage
  import mdma_ram_fifo_pkg::*;
#(
  parameter int  STG   = 2,
  parameter type ent_t = logic
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  ent_t                       i_ent,
  input  logic                       i_pop,
  output ent_t                       o_ent,
  output logic                       o_vld,
  output logic [$clog2(STG+1)-1:0]   o_cnt
);

  localparam int IW = (STG > 1) ? $clog2(STG) : 1;
  localparam int CW = $clog2(STG + 1);

  ent_t          r_mem [STG];
  logic [IW-1:0] r_wr;
  logic [IW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] idx);
    return (idx == IW'(STG - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign o_ent = r_mem[r_rd];
  assign o_vld = (r_cnt != '0);
  assign o_cnt = r_cnt;

  // The caller's credit rule keeps pushes away from a full buffer, so no guard is needed here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STG; k++) r_mem[k] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_ent;
        r_wr        <= nxt_idx(r_wr);
      end
      if (i_pop) r_rd <= nxt_idx(r_rd);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

endmodule

// File: rtl/mdma_ram_fifo_ctrl.sv
// FIFO controller for an external simple-dual-port ECC RAM, with prefetch staging and ECC error accounting.
module mdma_ram_fifo_ctrl
  import mdma_ram_fifo_pkg::*;
#(
  parameter int DATA_BITS    = 48,
  parameter int DEPTH        = 512,
  parameter int RAM_RD_LAT   = 1,
  parameter int AFULL_THRESH = DEPTH - 8,
  parameter int ERR_CNT_BITS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [DATA_BITS-1:0]       in_dat,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [DATA_BITS-1:0]       out_dat,
  output logic                       out_sbe,
  output logic                       out_dbe,
  output logic [$clog2(DEPTH)-1:0]   ram_wadr,
  output logic                       ram_wen,
  output logic [DATA_BITS-1:0]       ram_wdat,
  output logic                       ram_ren,
  output logic [$clog2(DEPTH)-1:0]   ram_radr,
  input  logic [DATA_BITS-1:0]       ram_rdat,
  input  logic                       ram_rsbe,
  input  logic                       ram_rdbe,
  output logic [$clog2(DEPTH)+1:0]   count,
  output logic                       almost_full,
  input  logic                       err_clr,
  output logic [ERR_CNT_BITS-1:0]    sbe_cnt,
  output logic [ERR_CNT_BITS-1:0]    dbe_cnt,
  output logic                       dbe_sticky
);

  localparam int AW  = $clog2(DEPTH);
  localparam int STG = RAM_RD_LAT + 1;
  localparam int SCW = $clog2(STG + 1);

  if (!mdma_ram_fifo_cfg_ok(DEPTH, RAM_RD_LAT)) begin : g_cfg_err
    $error("mdma_ram_fifo_ctrl: DEPTH must be a power of 2 >= 4 and RAM_RD_LAT must be 1 or 2");
  end

  typedef struct packed {
    logic [DATA_BITS-1:0] dat;
    logic                 sbe;
    logic                 dbe;
  } mdma_ram_ent_t;

  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [AW:0]             r_ram_occ;
  logic [RAM_RD_LAT-1:0]   r_inflt;
  logic [AW+1:0]           r_count;
  logic                    r_afull;
  logic [ERR_CNT_BITS-1:0] r_sbe_cnt;
  logic [ERR_CNT_BITS-1:0] r_dbe_cnt;
  logic                    r_dbe_sticky;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_issue;
  logic                    w_ret;
  logic                    w_sbe_ev;
  logic                    w_dbe_ev;
  logic                    w_stg_vld;
  logic [SCW-1:0]          w_inflt_cnt;
  logic [SCW-1:0]          w_stg_cnt;
  logic [SCW:0]            w_busy;
  logic [AW+1:0]           w_count_nxt;
  mdma_ram_ent_t           w_ret_ent;
  mdma_ram_ent_t           w_head;

  // in_rdy looks only at RAM occupancy, so a pop never opens the door for a push in the same cycle.
  assign in_rdy   = (r_ram_occ != (AW+1)'(DEPTH));
  assign w_push   = in_vld & in_rdy;
  assign ram_wen  = w_push;
  assign ram_wadr = r_wptr;
  assign ram_wdat = in_dat;

  always_comb begin
    w_inflt_cnt = '0;
    for (int k = 0; k < RAM_RD_LAT; k++) w_inflt_cnt = w_inflt_cnt + SCW'(r_inflt[k]);
  end

  // Reads are only issued while every outstanding return has a staging slot reserved for it.
  assign w_busy   = {1'b0, w_inflt_cnt} + {1'b0, w_stg_cnt};
  assign w_issue  = (r_ram_occ != '0) && (w_busy < (SCW+1)'(STG));
  assign ram_ren  = w_issue;
  assign ram_radr = r_rptr;

  // The oldest shift-register bit marks the cycle in which ram_rdat carries a requested word.
  assign w_ret         = r_inflt[RAM_RD_LAT-1];
  assign w_ret_ent.dat = ram_rdat;
  assign w_ret_ent.dbe = ram_rdbe;
  assign w_ret_ent.sbe = ram_rsbe & ~ram_rdbe;
  assign w_sbe_ev      = w_ret & ram_rsbe & ~ram_rdbe;
  assign w_dbe_ev      = w_ret & ram_rdbe;

  mdma_ram_fifo_stage #(
    .STG   (STG),
    .ent_t (mdma_ram_ent_t)
  ) u_stage (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_ret),
    .i_ent  (w_ret_ent),
    .i_pop  (w_pop),
    .o_ent  (w_head),
    .o_vld  (w_stg_vld),
    .o_cnt  (w_stg_cnt)
  );

  assign out_vld = w_stg_vld;
  assign out_dat = w_head.dat;
  assign out_sbe = w_head.sbe;
  assign out_dbe = w_head.dbe;
  assign w_pop   = w_stg_vld & out_rdy;

  assign w_count_nxt = r_count + (AW+2)'(w_push) - (AW+2)'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_occ <= '0;
      r_inflt   <= '0;
      r_count   <= '0;
      r_afull   <= 1'b0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + 1'b1;
      if (w_issue) r_rptr <= r_rptr + 1'b1;
      r_ram_occ <= r_ram_occ + (AW+1)'(w_push) - (AW+1)'(w_issue);
      r_inflt   <= RAM_RD_LAT'({r_inflt, w_issue});
      r_count   <= w_count_nxt;
      r_afull   <= (w_count_nxt >= (AW+2)'(AFULL_THRESH));
    end
  end

  // An error event coinciding with err_clr wins: the counter restarts at 1 rather than 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sbe_cnt    <= '0;
      r_dbe_cnt    <= '0;
      r_dbe_sticky <= 1'b0;
    end else begin
      if (w_sbe_ev)     r_sbe_cnt <= err_clr ? ERR_CNT_BITS'(1) :
                                     ((&r_sbe_cnt) ? r_sbe_cnt : r_sbe_cnt + 1'b1);
      else if (err_clr) r_sbe_cnt <= '0;

      if (w_dbe_ev)     r_dbe_cnt <= err_clr ? ERR_CNT_BITS'(1) :
                                     ((&r_dbe_cnt) ? r_dbe_cnt : r_dbe_cnt + 1'b1);
      else if (err_clr) r_dbe_cnt <= '0;

      if (w_dbe_ev)     r_dbe_sticky <= 1'b1;
      else if (err_clr) r_dbe_sticky <= 1'b0;
    end
  end

  assign count       = r_count;
  assign almost_full = r_afull;
  assign sbe_cnt     = r_sbe_cnt;
  assign dbe_cnt     = r_dbe_cnt;
  assign dbe_sticky  = r_dbe_sticky;

endmodule
